// File: rtl/pipelined_csel_addsub_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
//   - ALU op encodings driven on in_sub.
//   - Segment-count helper used to size the carry-select generate loop.
package pipelined_csel_addsub_pkg;

    localparam logic AluOpAdd = 1'b0;
    localparam logic AluOpSub = 1'b1;

    // Number of carry-select segments for a given operand width.
    function automatic int unsigned seg_count(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/pipelined_csel_addsub_segment.sv
// One carry-select segment: adds a and b twice, once assuming carry-in 0 and once
// assuming carry-in 1, so the real carry can pick a result later.
// Ports:
//   a, b          in   SEG-bit operand slices (b already inverted for subtract)
//   sum0, c0      out  sum and carry-out assuming carry-in 0
//   sum1, c1      out  sum and carry-out assuming carry-in 1
//   msbc0, msbc1  out  carry into the slice MSB for each assumption
module pipelined_csel_addsub_segment
    import pipelined_csel_addsub_pkg::*;
#(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    output logic [SEG-1:0] sum0,
    output logic [SEG-1:0] sum1,
    output logic           c0,
    output logic           c1,
    output logic           msbc0,
    output logic           msbc1
);

    logic [SEG:0] full0;
    logic [SEG:0] full1;

    assign full0 = {1'b0, a} + {1'b0, b};
    assign full1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};

    assign sum0 = full0[SEG-1:0];
    assign sum1 = full1[SEG-1:0];
    assign c0   = full0[SEG];
    assign c1   = full1[SEG];

    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the XOR.
    assign msbc0 = full0[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
    assign msbc1 = full1[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_csel_addsub.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
//   S1: every segment computes both carry-in hypotheses; segment 0 resolves with the
//       effective carry-in. S2: a select chain resolves segment carries, flags registered.
// Ports:
//   clock, reset_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready         input handshake; in_ready is combinational from out_ready
//   in_sub                    0: a+b+in_cin, 1: a-b (in_cin ignored)
//   in_a, in_b, in_cin        operands and add-mode carry-in
//   out_valid/out_ready       output handshake
//   out_sum                   result modulo 2^WIDTH
//   out_cout                  carry out of MSB (subtract: 1 = no borrow)
//   out_of                    signed overflow
//   out_zero                  out_sum == 0
module pipelined_csel_addsub
    import pipelined_csel_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_of,
    output logic             out_zero
);

    localparam int unsigned NSEG = seg_count(WIDTH, SEG);
    localparam int unsigned HI   = WIDTH - SEG;

    // Handshake
    logic s1_valid;
    logic s2_valid;
    logic adv1;
    logic adv2;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Stage 1 combinational
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff   = (in_sub == AluOpSub) ? ~in_b : in_b;
    assign cin_eff = (in_sub == AluOpSub) ? 1'b1 : in_cin;

    logic [SEG-1:0]  seg_sum0 [NSEG];
    logic [SEG-1:0]  seg_sum1 [NSEG];
    logic [NSEG-1:0] seg_c0;
    logic [NSEG-1:0] seg_c1;
    logic [NSEG-1:0] seg_msbc0;
    logic [NSEG-1:0] seg_msbc1;

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        pipelined_csel_addsub_segment #(
            .SEG(SEG)
        ) u_seg (
            .a     (in_a[i*SEG +: SEG]),
            .b     (b_eff[i*SEG +: SEG]),
            .sum0  (seg_sum0[i]),
            .sum1  (seg_sum1[i]),
            .c0    (seg_c0[i]),
            .c1    (seg_c1[i]),
            .msbc0 (seg_msbc0[i]),
            .msbc1 (seg_msbc1[i])
        );
    end

    logic [HI-1:0] hi_sum0;
    logic [HI-1:0] hi_sum1;

    for (genvar i = 1; i < NSEG; i++) begin : g_hi
        assign hi_sum0[(i-1)*SEG +: SEG] = seg_sum0[i];
        assign hi_sum1[(i-1)*SEG +: SEG] = seg_sum1[i];
    end

    // Segment 0 knows its carry-in now, so it resolves in S1.
    logic [SEG-1:0] lo_sum;
    logic           lo_c;

    assign lo_sum = cin_eff ? seg_sum1[0] : seg_sum0[0];
    assign lo_c   = cin_eff ? seg_c1[0]   : seg_c0[0];

    // Only the top segment's MSB carry feeds the overflow flag.
    logic unused_msbc;
    assign unused_msbc = ^{seg_msbc0[NSEG-2:0], seg_msbc1[NSEG-2:0]};

    // Stage 1 registers
    logic [SEG-1:0]  s1_lo_sum;
    logic            s1_lo_c;
    logic [HI-1:0]   s1_hi_sum0;
    logic [HI-1:0]   s1_hi_sum1;
    logic [NSEG-2:0] s1_hi_c0;
    logic [NSEG-2:0] s1_hi_c1;
    logic            s1_msbc0;
    logic            s1_msbc1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_lo_sum  <= '0;
            s1_lo_c    <= 1'b0;
            s1_hi_sum0 <= '0;
            s1_hi_sum1 <= '0;
            s1_hi_c0   <= '0;
            s1_hi_c1   <= '0;
            s1_msbc0   <= 1'b0;
            s1_msbc1   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo_sum  <= lo_sum;
                s1_lo_c    <= lo_c;
                s1_hi_sum0 <= hi_sum0;
                s1_hi_sum1 <= hi_sum1;
                s1_hi_c0   <= seg_c0[NSEG-1:1];
                s1_hi_c1   <= seg_c1[NSEG-1:1];
                s1_msbc0   <= seg_msbc0[NSEG-1];
                s1_msbc1   <= seg_msbc1[NSEG-1];
            end
        end
    end

    // Stage 2 select chain
    logic [WIDTH-1:0] sum_d;
    logic             carry;
    logic             msb_carry;
    logic             cout_d;
    logic             of_d;
    logic             zero_d;

    always_comb begin
        sum_d            = '0;
        carry            = s1_lo_c;
        msb_carry        = 1'b0;
        sum_d[SEG-1:0]   = s1_lo_sum;
        for (int unsigned i = 1; i < NSEG; i++) begin
            sum_d[i*SEG +: SEG] = carry ? s1_hi_sum1[(i-1)*SEG +: SEG]
                                        : s1_hi_sum0[(i-1)*SEG +: SEG];
            if (i == NSEG - 1) begin
                msb_carry = carry ? s1_msbc1 : s1_msbc0;
            end
            carry = carry ? s1_hi_c1[i-1] : s1_hi_c0[i-1];
        end
        cout_d = carry;
        of_d   = msb_carry ^ carry;
        zero_d = (sum_d == '0);
    end

    // Stage 2 registers drive the outputs directly; they hold while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_of   <= 1'b0;
            out_zero <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_d;
                out_cout <= cout_d;
                out_of   <= of_d;
                out_zero <= zero_d;
            end
        end
    end

endmodule
